// File: rtl/serial_pkg.sv
// Shared definitions for the serial link blocks (receiver now, transmitter later).
package serial_pkg;

    localparam int DATA_W_DEF       = 8;
    localparam int CLKS_PER_BIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } serial_state_t;

endpackage

// File: rtl/serial_rx_if.sv
// Serial line plus received-word valid/ready buffer. Slave = receiver, master = line driver/consumer.
interface serial_rx_if
    import serial_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              serial_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              frame_err;
    logic              overrun;

    modport master (
        output serial_in,
        output data_ready,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  serial_in,
        input  data_ready,
        output data_out,
        output data_valid,
        output frame_err,
        output overrun
    );

endinterface

// File: rtl/serial_bit_timer.sv
// Free-running per-bit cycle counter; clear restarts it at 0 so the strobes align to a line edge.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_mid,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] MID_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] END_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == END_CNT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // bit_mid fires CLKS_PER_BIT/2 cycles after a clear; bit_end once per full bit period.
    assign bit_mid = (cnt == MID_CNT);
    assign bit_end = (cnt == END_CNT);

endmodule

// File: rtl/serial_rx.sv
// Serial receiver: start/data/stop framing into a one-word output buffer.
// Handshake: a word transfers on a rising edge with data_valid=1 and data_ready=1; data_out holds while valid && !ready.
module serial_rx
    import serial_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    serial_rx_if.slave    bus,
    output serial_state_t dbg_state
);

    localparam int IW = $clog2(DATA_W + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    serial_state_t     state, state_next;
    logic              timer_clear;
    logic              bit_mid, bit_end;
    logic              sample_bit;
    logic              stop_ok, stop_bad;
    logic              load;
    logic [IW-1:0]     bit_idx;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] out_word;
    logic              out_valid;
    logic              ferr_q;
    logic              ovr_q;

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .bit_mid(bit_mid),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        timer_clear = 1'b0;
        sample_bit  = 1'b0;
        stop_ok     = 1'b0;
        stop_bad    = 1'b0;
        case (state)
            IDLE: begin
                // Timer held at 0 so START counts from the falling edge.
                timer_clear = 1'b1;
                if (!bus.serial_in) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_mid) begin
                    timer_clear = 1'b1;
                    state_next  = bus.serial_in ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    sample_bit = 1'b1;
                    if (bit_idx == LAST_IDX) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    stop_ok    = bus.serial_in;
                    stop_bad   = !bus.serial_in;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A good frame loads only if the buffer is empty or drains on this same edge.
    assign load = stop_ok && (!out_valid || bus.data_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_idx   <= '0;
            shift_reg <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            ferr_q <= stop_bad;
            ovr_q  <= stop_ok && out_valid && !bus.data_ready;
            if (state == IDLE) begin
                bit_idx <= '0;
            end else if (sample_bit) begin
                shift_reg <= {bus.serial_in, shift_reg[DATA_W-1:1]};
                bit_idx   <= (bit_idx == LAST_IDX) ? '0 : bit_idx + IW'(1);
            end
            if (load) begin
                out_word  <= shift_reg;
                out_valid <= 1'b1;
            end else if (out_valid && bus.data_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.data_out   = out_word;
    assign bus.data_valid = out_valid;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: expected events queued by the stimulus, popped by a negedge monitor.
module tb_serial_rx;
    import serial_pkg::*;

    localparam int DW   = 8;
    localparam int CLKS = 4;
    localparam int W    = 10;
    localparam logic [1:0] K_WORD = 2'd1;
    localparam logic [1:0] K_FERR = 2'd2;
    localparam logic [1:0] K_OVR  = 2'd3;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    serial_state_t dbg_state;

    logic [W-1:0] exp_q[$];
    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int frame_start = 0;
    int rise_cyc    = 0;
    int hi_cnt      = 0;
    logic prev_valid = 1'b0;

    serial_rx_if #(.DATA_W(DW)) sif ();

    serial_rx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CLKS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (sif),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // scoreboard
    task automatic sb_event(input logic [W-1:0] got, input string name);
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event kind=%0d data=%h, required no event", name, got[9:8], got[7:0]);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got kind=%0d data=%h, required kind=%0d data=%h",
                         name, got[9:8], got[7:0], e[9:8], e[7:0]);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
            end else begin
                if (sif.data_valid && !prev_valid) rise_cyc = cyc;
                if (sif.data_valid) hi_cnt++;
                prev_valid = sif.data_valid;
                if (sif.frame_err) sb_event({K_FERR, 8'h00}, "frame_err");
                if (sif.overrun) sb_event({K_OVR, 8'h00}, "overrun");
                if (sif.data_valid && sif.data_ready) sb_event({K_WORD, sif.data_out}, "word");
            end
        end
    end

    // drivers
    task automatic hold_bit();
        repeat (CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        @(posedge clk);
        #1;
        sif.serial_in = 1'b0;
        frame_start = cyc + 1;
        hold_bit();
        for (int i = 0; i < DW; i++) begin
            sif.serial_in = d[i];
            hold_bit();
        end
        sif.serial_in = stop_bit;
        hold_bit();
        sif.serial_in = 1'b1;
    endtask

    task automatic drain_check(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        sif.serial_in  = 1'b1;
        sif.data_ready = 1'b1;
        reset          = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'(dbg_state), 32'(IDLE));
        chk("reset_data_valid", 32'(sif.data_valid), 32'd0);
        chk("reset_data_out", 32'(sif.data_out), 32'd0);
        chk("reset_frame_err", 32'(sif.frame_err), 32'd0);
        chk("reset_overrun", 32'(sif.overrun), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // 0xA5, consumer always ready: valid for exactly one cycle, one cycle after the stop sample
        hi_cnt = 0;
        exp_q.push_back({K_WORD, 8'hA5});
        send_frame(8'hA5, 1'b1);
        drain_check("a5_drain");
        chk("a5_latency", 32'(rise_cyc), 32'(frame_start + CLKS / 2 + CLKS * (DW + 1)));
        chk("a5_valid_cycles", 32'(hi_cnt), 32'd1);

        // two-cycle low glitch on the idle line
        @(posedge clk);
        #1;
        sif.serial_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("glitch_in_start", 32'(dbg_state), 32'(START));
        @(posedge clk);
        #1;
        sif.serial_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("glitch_back_idle", 32'(dbg_state), 32'(IDLE));
        chk("glitch_no_valid", 32'(sif.data_valid), 32'd0);
        drain_check("glitch_drain");

        // 0x3C with a bad stop bit
        exp_q.push_back({K_FERR, 8'h00});
        send_frame(8'h3C, 1'b0);
        drain_check("ferr_drain");
        @(negedge clk);
        chk("ferr_no_valid", 32'(sif.data_valid), 32'd0);

        // 0x11 then 0x22 with the buffer held: second frame overruns
        sif.data_ready = 1'b0;
        exp_q.push_back({K_OVR, 8'h00});
        exp_q.push_back({K_WORD, 8'h11});
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        @(negedge clk);
        chk("ovr_held_data", 32'(sif.data_out), 32'h11);
        chk("ovr_held_valid", 32'(sif.data_valid), 32'd1);
        @(posedge clk);
        #1;
        sif.data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ovr_after_accept", 32'(sif.data_valid), 32'd0);
        drain_check("ovr_drain");

        // back-to-back 0x01, 0x80: accept 0x01 on the very edge 0x80 loads
        sif.data_ready = 1'b0;
        exp_q.push_back({K_WORD, 8'h01});
        exp_q.push_back({K_WORD, 8'h80});
        send_frame(8'h01, 1'b1);
        fork
            send_frame(8'h80, 1'b1);
            begin
                repeat (CLKS / 2 + CLKS * (DW + 1) + 1) @(posedge clk);
                #1;
                sif.data_ready = 1'b1;
                @(posedge clk);
                #1;
                sif.data_ready = 1'b0;
            end
        join
        @(negedge clk);
        chk("b2b_data", 32'(sif.data_out), 32'h80);
        chk("b2b_valid", 32'(sif.data_valid), 32'd1);
        @(posedge clk);
        #1;
        sif.data_ready = 1'b1;
        drain_check("b2b_drain");

        // reset during data bit 3 of 0xFF, then a clean 0x5A
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (CLKS * 4 + 2) @(posedge clk);
                #1;
                reset = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b0;
            end
        join
        drain_check("rst_partial_drain");
        @(negedge clk);
        chk("rst_state_idle", 32'(dbg_state), 32'(IDLE));
        chk("rst_no_valid", 32'(sif.data_valid), 32'd0);
        exp_q.push_back({K_WORD, 8'h5A});
        send_frame(8'h5A, 1'b1);
        drain_check("rst_5a_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
